// File: rtl/signal_types_pkg.sv
// Shared types and constants for the ADC capture buffer and its readers.
package signal_types_pkg;

    // One captured ADC sample as stored in the DPRAM.
    typedef logic [31:0] adc_sample_t;

    // Buffer geometry, shared by the capture writer and the readout streamer.
    localparam int                         ADC_BUF_ADDR_BITS = 13;
    localparam logic [ADC_BUF_ADDR_BITS-1:0] ADC_BUF_START   = 13'h400;
    localparam logic [ADC_BUF_ADDR_BITS-1:0] ADC_BUF_SPAN    = 13'h1000;

    // Readout controller states.
    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_STREAM = 2'd1,
        RD_DONE   = 2'd2
    } rd_state_t;

    // Output FIFO entry: the sample plus its end-of-buffer marker.
    typedef struct packed {
        logic        last;
        adc_sample_t data;
    } fifo_entry_t;

endpackage

// File: rtl/adc_stream_fifo.sv
// Small synchronous FIFO holding readout samples between the DPRAM read
// port and the output stream. Flush empties it without touching storage.
module adc_stream_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 33,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
);

    localparam int               PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]    LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q;
    logic [PW-1:0]     wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_C);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    // A push into a full FIFO is only accepted when the head leaves the same cycle.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;

    // Pointer, occupancy and storage update; reset also clears storage so the head reads 0.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ptr_next(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            count_q <= count_q + {{(CNT_W-1){1'b0}}, do_push} - {{(CNT_W-1){1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/adc_buf_streamer.sv
// Reads the full ADC capture buffer back through the DPRAM read port and
// emits it as a valid/ready stream with a last marker.
//
// Stream handshake: m_valid_o is high whenever the FIFO holds a sample and
// does not depend on m_ready_i; once high, m_data_o/m_last_o hold until the
// beat is taken; a beat transfers on the rising edge where both are high.
//
// Reads are issued against a credit: a read goes out only if the FIFO will
// have room for it when the DPRAM answers one cycle later, counting the read
// already in flight and any beat leaving this cycle.
module adc_buf_streamer
    import signal_types_pkg::*;
#(
    parameter int                   ADDR_BITS  = ADC_BUF_ADDR_BITS,
    parameter logic [ADDR_BITS-1:0] ADDR_START = ADC_BUF_START,
    parameter logic [ADDR_BITS-1:0] ADDR_SPAN  = ADC_BUF_SPAN,
    parameter int                   FIFO_DEPTH = 2
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 csr_done_i,
    input  logic                 csr_start_i,
    input  logic                 csr_abort_i,
    output logic                 csr_busy_o,
    output logic                 csr_rd_done_o,
    output logic                 csr_err_o,
    output logic                 rd_en_o,
    output logic [ADDR_BITS-1:0] rd_addr_o,
    input  logic [31:0]          rd_data_i,
    output logic                 m_valid_o,
    output logic [31:0]          m_data_o,
    output logic                 m_last_o,
    input  logic                 m_ready_i,
    output logic [1:0]           dbg_state_o
);

    localparam int                   CW       = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]          DEPTH_W  = (CW + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_BITS:0]   SPAN_W   = {1'b0, ADDR_SPAN};
    localparam logic [ADDR_BITS:0]   LAST_IDX = SPAN_W - 1'b1;

    rd_state_t            state_q;
    rd_state_t            state_d;
    logic [ADDR_BITS-1:0] issue_addr_q;
    logic [ADDR_BITS:0]   issued_q;
    logic                 inflight_q;
    logic                 inflight_last_q;
    logic                 rd_done_q;
    logic                 err_q;

    logic [CW-1:0]        fifo_count;
    logic                 fifo_empty;
    logic                 fifo_full;
    fifo_entry_t          wr_entry;
    fifo_entry_t          head_entry;

    logic                 pop;
    logic                 rd_en;
    logic                 start_ok;
    logic                 start_bad;
    logic                 abort_run;
    logic                 last_pop;
    logic [CW:0]          occ;

    assign m_valid_o     = ~fifo_empty;
    assign m_data_o      = head_entry.data;
    assign m_last_o      = head_entry.last;
    assign pop           = m_valid_o & m_ready_i;
    assign rd_en_o       = rd_en;
    assign rd_addr_o     = issue_addr_q;
    assign csr_busy_o    = (state_q == RD_STREAM);
    assign csr_rd_done_o = rd_done_q;
    assign csr_err_o     = err_q;
    assign dbg_state_o   = state_q;
    assign wr_entry      = '{last: inflight_last_q, data: rd_data_i};

    // Next state, read issue and start/abort/completion decode.
    always_comb begin
        state_d   = state_q;
        rd_en     = 1'b0;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        abort_run = 1'b0;
        last_pop  = 1'b0;
        occ       = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
        case (state_q)
            RD_IDLE, RD_DONE: begin
                if (csr_start_i) begin
                    if (csr_done_i) begin
                        start_ok = 1'b1;
                        state_d  = RD_STREAM;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            RD_STREAM: begin
                // fifo_full term is implied by the credit check; kept as a local safety net.
                if ((issued_q < SPAN_W) && (occ < DEPTH_W) && !(fifo_full && !pop)) begin
                    rd_en = 1'b1;
                end
                if (csr_abort_i) begin
                    abort_run = 1'b1;
                    state_d   = RD_IDLE;
                end else if (pop && head_entry.last) begin
                    last_pop = 1'b1;
                    state_d  = RD_DONE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= RD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Issue address/counter, in-flight tracking and sticky status flags.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            issue_addr_q    <= ADDR_START;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            rd_done_q       <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            // A read answered after an abort has nowhere to go, so it is dropped here.
            inflight_q      <= rd_en & ~abort_run;
            inflight_last_q <= (issued_q == LAST_IDX);
            if (start_ok) begin
                issue_addr_q <= ADDR_START;
                issued_q     <= '0;
                rd_done_q    <= 1'b0;
                err_q        <= 1'b0;
            end else if (rd_en) begin
                issue_addr_q <= issue_addr_q + 1'b1;
                issued_q     <= issued_q + 1'b1;
            end
            if (start_bad) begin
                err_q <= 1'b1;
            end
            if (last_pop) begin
                rd_done_q <= 1'b1;
            end
        end
    end

    adc_stream_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W ($bits(fifo_entry_t)),
        .CNT_W  (CW)
    ) u_fifo (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .push    (inflight_q),
        .pop     (pop),
        .flush   (abort_run),
        .wdata   (wr_entry),
        .rdata   (head_entry),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

endmodule

// File: tb/tb_adc_buf_streamer.sv
// Directed bench for adc_buf_streamer: DPRAM model, negedge stream monitor
// with an expected-sample queue, and a sequenced set of readout scenarios.
module tb_adc_buf_streamer;

    localparam int          SPAN   = 4096;
    localparam logic [12:0] START  = 13'h400;
    localparam logic [12:0] TOP    = 13'h13FF;

    // ---------------- clock / reset ----------------
    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    logic        csr_done_i  = 1'b0;
    logic        csr_start_i = 1'b0;
    logic        csr_abort_i = 1'b0;
    logic        csr_busy_o;
    logic        csr_rd_done_o;
    logic        csr_err_o;
    logic        rd_en_o;
    logic [12:0] rd_addr_o;
    logic [31:0] rd_data_i = '0;
    logic        m_valid_o;
    logic [31:0] m_data_o;
    logic        m_last_o;
    logic        m_ready_i = 1'b0;
    logic [1:0]  dbg_state_o;

    adc_buf_streamer #(
        .ADDR_BITS  (13),
        .ADDR_START (13'h400),
        .ADDR_SPAN  (13'h1000),
        .FIFO_DEPTH (2)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .csr_done_i    (csr_done_i),
        .csr_start_i   (csr_start_i),
        .csr_abort_i   (csr_abort_i),
        .csr_busy_o    (csr_busy_o),
        .csr_rd_done_o (csr_rd_done_o),
        .csr_err_o     (csr_err_o),
        .rd_en_o       (rd_en_o),
        .rd_addr_o     (rd_addr_o),
        .rd_data_i     (rd_data_i),
        .m_valid_o     (m_valid_o),
        .m_data_o      (m_data_o),
        .m_last_o      (m_last_o),
        .m_ready_i     (m_ready_i),
        .dbg_state_o   (dbg_state_o)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Buffer contents: unique per address so misordering or repeats are visible.
    function automatic logic [31:0] mem_word(input logic [12:0] a);
        return {a[7:0] ^ 8'h5A, 3'b101, a, ~a[7:0]};
    endfunction

    // DPRAM read port model: one cycle of read latency.
    always @(posedge sys_clk) begin
        if (rd_en_o) rd_data_i <= mem_word(rd_addr_o);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [31:0] exp_q[$];
    int          run_id   = 0;
    int          seen_id  = 0;
    bit          mon_en   = 1'b0;
    int          beats    = 0;
    int          rd_idx   = 0;
    int          first_beat_cyc = 0;
    int          last_beat_cyc  = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic        prev_last  = 1'b0;

    always @(negedge sys_clk) begin
        if (seen_id != run_id) begin
            seen_id = run_id;
            exp_q.delete();
            for (int i = 0; i < SPAN; i++) exp_q.push_back(mem_word(13'(int'(START) + i)));
            beats = 0;
            rd_idx = 0;
            prev_stall = 1'b0;
        end
        if (mon_en) begin
            if (prev_stall) begin
                check("stall_valid", m_valid_o, 1);
                check("stall_data", m_data_o, prev_data);
                check("stall_last", m_last_o, prev_last);
            end
            if (rd_en_o) begin
                check("rd_addr", rd_addr_o, 32'(int'(START) + rd_idx));
                check("rd_addr_max", rd_addr_o <= TOP, 1);
                check("rd_credit", (rd_idx - beats - int'(m_valid_o && m_ready_i)) <= 1, 1);
                rd_idx++;
            end
            if (m_valid_o && m_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("beat_extra", exp_q.size(), 1);
                end else begin
                    check("beat_data", m_data_o, exp_q.pop_front());
                    check("beat_last", m_last_o, beats == SPAN - 1);
                end
                if (beats == 0) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
                beats++;
            end
            prev_stall = m_valid_o && !m_ready_i && !csr_abort_i && !sys_rst;
            prev_data  = m_data_o;
            prev_last  = m_last_o;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic start_run();
        run_id++;
        csr_start_i = 1'b1;
        tick();
        csr_start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget, input bit rnd);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (csr_rd_done_o) break;
            if (rnd) m_ready_i = 1'($urandom_range(0, 1));
        end
        check(tag, csr_rd_done_o, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},    csr_busy_o, 0);
        check({tag, "_rd_done"}, csr_rd_done_o, 0);
        check({tag, "_err"},     csr_err_o, 0);
        check({tag, "_rd_en"},   rd_en_o, 0);
        check({tag, "_rd_addr"}, rd_addr_o, 13'h400);
        check({tag, "_valid"},   m_valid_o, 0);
        check({tag, "_data"},    m_data_o, 0);
        check({tag, "_last"},    m_last_o, 0);
        check({tag, "_state"},   dbg_state_o, 0);
    endtask

    task automatic check_full_run(input string tag);
        check({tag, "_beats"},   beats, SPAN);
        check({tag, "_left"},    exp_q.size(), 0);
        check({tag, "_busy"},    csr_busy_o, 0);
        check({tag, "_state"},   dbg_state_o, 2);
    endtask

    // ---------------- sequence ----------------
    initial begin
        int quiet;
        int saved;

        repeat (3) tick();
        check_reset_outputs("reset");
        sys_rst = 1'b0;
        mon_en  = 1'b1;
        tick();

        // Start while the buffer is not full: flagged, no readout.
        csr_done_i = 1'b0;
        csr_start_i = 1'b1;
        tick();
        csr_start_i = 1'b0;
        check("err_set", csr_err_o, 1);
        check("err_state_idle", dbg_state_o, 0);
        check("err_busy", csr_busy_o, 0);
        repeat (3) tick();
        check("err_no_reads", rd_idx, 0);
        check("err_sticky", csr_err_o, 1);

        // Valid start, ready held high: latency, gap-free full run.
        csr_done_i = 1'b1;
        m_ready_i  = 1'b1;
        start_run();
        check("run1_err_clear", csr_err_o, 0);
        check("run1_busy", csr_busy_o, 1);
        check("run1_rd_en", rd_en_o, 1);
        check("run1_valid_c0", m_valid_o, 0);
        tick();
        check("run1_valid_c1", m_valid_o, 0);
        tick();
        check("run1_valid_c2", m_valid_o, 1);
        check("run1_first_data", m_data_o, 32'hA5A0_FF00 ^ 32'hA5A0_FF00 ^ {8'h5A, 3'b101, 13'h400, 8'hFF});
        wait_done("run1_done", 6000, 1'b0);
        check_full_run("run1");
        check("run1_no_bubbles", last_beat_cyc - first_beat_cyc, SPAN - 1);

        // Restart from DONE: identical stream again.
        start_run();
        check("run2_rd_done_clear", csr_rd_done_o, 0);
        wait_done("run2_done", 6000, 1'b0);
        check_full_run("run2");
        check("run2_no_bubbles", last_beat_cyc - first_beat_cyc, SPAN - 1);

        // Random backpressure: order, count, stability and credit covered by the monitor.
        start_run();
        wait_done("run3_done", 20000, 1'b1);
        check_full_run("run3");

        // Abort with a full FIFO and the sink stalled.
        m_ready_i = 1'b1;
        start_run();
        for (int i = 0; i < 500; i++) begin
            if (beats >= 100) break;
            tick();
        end
        m_ready_i = 1'b0;
        repeat (4) tick();
        check("abort_pre_valid", m_valid_o, 1);
        check("abort_full_no_rd", rd_en_o, 0);
        csr_abort_i = 1'b1;
        csr_start_i = 1'b1;
        tick();
        csr_abort_i = 1'b0;
        csr_start_i = 1'b0;
        check("abort_valid", m_valid_o, 0);
        check("abort_busy", csr_busy_o, 0);
        check("abort_rd_done", csr_rd_done_o, 0);
        check("abort_state", dbg_state_o, 0);
        quiet = 0;
        m_ready_i = 1'b1;
        repeat (5) begin
            tick();
            quiet += int'(m_valid_o) + int'(rd_en_o);
        end
        check("abort_quiet", quiet, 0);

        // Restream from the buffer start, then reset at beat 2000.
        start_run();
        check("restart_addr", rd_addr_o, 13'h400);
        for (int i = 0; i < 3000; i++) begin
            if (beats >= 2000) break;
            tick();
        end
        check("pre_reset_busy", csr_busy_o, 1);
        sys_rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        saved = beats;
        tick();
        sys_rst = 1'b0;
        quiet = 0;
        repeat (20) begin
            tick();
            quiet += int'(m_valid_o) + int'(rd_en_o);
        end
        check("midrst_quiet", quiet, 0);
        check("midrst_no_beats", beats, saved);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
